// File: rtl/ahb_sram_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_sram_ctrl_if                                             |
// | Description : AHB-Lite slave bus plus single SRAM port bundle.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface ahb_sram_ctrl_if #(
   parameter int AW = 12
);
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic          SRAM_CSN;
   logic [AW-1:0] SRAM_ADDR;
   logic          SRAM_WE;
   logic [3:0]    SRAM_BE;
   logic [31:0]   SRAM_DI;
   logic [31:0]   SRAM_DO;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA,
      output SRAM_CSN, SRAM_ADDR, SRAM_WE, SRAM_BE, SRAM_DI,
      input  SRAM_DO
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA,
      input  SRAM_CSN, SRAM_ADDR, SRAM_WE, SRAM_BE, SRAM_DI,
      output SRAM_DO
   );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_sram_ctrl                                                |
// | Description : Zero-wait-state AHB-Lite to single-port SRAM bridge with a   |
// |               one-entry write buffer and read forwarding.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ahb_sram_ctrl #(
   parameter int AW = 12
) (
   input  logic           CLK,
   input  logic           RST,
   ahb_sram_ctrl_if.slave bus
);
   localparam logic [3:0] c_BE_FULL = 4'b1111;

   logic          w_accept;
   logic          w_rd_strobe;
   logic          w_dp_wr;
   logic          w_fwd_hit;
   logic [AW-1:0] w_haddr_word;
   logic [3:0]    w_lane_mask;
   logic [31:0]   w_rdata;

   logic          w_csn;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [3:0]    w_be;
   logic [31:0]   w_di;

   logic          r_dp_valid;
   logic          r_dp_write;
   logic [AW-1:0] r_dp_addr;
   logic [3:0]    r_dp_be;
   logic          r_wb_valid;
   logic [AW-1:0] r_wb_addr;
   logic [3:0]    r_wb_be;
   logic [31:0]   r_wb_data;

   logic          w_unused_bits;

   // Address bits above the SRAM word range alias; they are intentionally dropped.
   assign w_unused_bits = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

   assign w_accept     = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
   assign w_rd_strobe  = w_accept & ~bus.HWRITE;
   assign w_dp_wr      = r_dp_valid & r_dp_write;
   assign w_haddr_word = bus.HADDR[AW+1:2];

   always_comb begin
      w_lane_mask = c_BE_FULL;
      case (bus.HSIZE)
         3'd0:    w_lane_mask = 4'b0001 << bus.HADDR[1:0];
         3'd1:    w_lane_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
         default: w_lane_mask = c_BE_FULL;
      endcase
   end

   // A new read address always wins the port; a colliding write data phase is parked.
   always_comb begin
      w_csn  = 1'b1;
      w_we   = 1'b0;
      w_addr = '0;
      w_be   = 4'b0000;
      w_di   = 32'h0;
      if (!RST) begin
         if (w_rd_strobe) begin
            w_csn  = 1'b0;
            w_addr = w_haddr_word;
            w_be   = c_BE_FULL;
         end else if (w_dp_wr) begin
            w_csn  = 1'b0;
            w_we   = 1'b1;
            w_addr = r_dp_addr;
            w_be   = r_dp_be;
            w_di   = bus.HWDATA;
         end else if (r_wb_valid) begin
            w_csn  = 1'b0;
            w_we   = 1'b1;
            w_addr = r_wb_addr;
            w_be   = r_wb_be;
            w_di   = r_wb_data;
         end
      end
   end

   assign bus.SRAM_CSN  = w_csn;
   assign bus.SRAM_WE   = w_we;
   assign bus.SRAM_ADDR = w_addr;
   assign bus.SRAM_BE   = w_be;
   assign bus.SRAM_DI   = w_di;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_addr  <= '0;
         r_dp_be    <= 4'b0000;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_be    <= 4'b0000;
         r_wb_data  <= 32'h0;
      end else begin
         r_dp_valid <= w_accept;
         r_dp_write <= w_accept & bus.HWRITE;
         r_dp_addr  <= w_accept ? w_haddr_word : '0;
         r_dp_be    <= w_accept ? w_lane_mask : 4'b0000;
         if (w_rd_strobe && w_dp_wr) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_dp_addr;
            r_wb_be    <= r_dp_be;
            r_wb_data  <= bus.HWDATA;
         end else if (!w_rd_strobe && !w_dp_wr && r_wb_valid) begin
            r_wb_valid <= 1'b0;
         end
      end
   end

   assign w_fwd_hit = r_wb_valid & (r_wb_addr == r_dp_addr);

   generate
      for (genvar i = 0; i < 4; i++) begin : g_lane
         assign w_rdata[8*i +: 8] = (w_fwd_hit & r_wb_be[i]) ? r_wb_data[8*i +: 8]
                                                             : bus.SRAM_DO[8*i +: 8];
      end
   endgenerate

   assign bus.HRDATA    = (!RST && r_dp_valid && !r_dp_write) ? w_rdata : 32'h0;
   assign bus.HREADYOUT = 1'b1;
   assign bus.HRESP     = 1'b0;

   // A buffered write can only coexist with read data phases; anything else is a design bug.
   property p_wb_no_collision;
      @(posedge CLK) disable iff (RST) r_wb_valid |-> !w_dp_wr;
   endproperty
   a_wb_no_collision: assert property (p_wb_no_collision);
endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ahb_sram_ctrl                                             |
// | Description : Directed self-checking bench for ahb_sram_ctrl.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ahb_sram_ctrl;
   localparam int AW = 12;
   localparam logic [49:0] c_IDLE = {1'b1, 1'b0, 12'd0, 4'h0, 32'h0};

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   ahb_sram_ctrl_if #(.AW(AW)) bus ();
   ahb_sram_ctrl #(.AW(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   // SRAM model: byte-lane writes, registered read data.
   logic [31:0] mem [0:(1<<AW)-1];
   logic [31:0] sram_do;
   logic        mem_clr;
   always @(posedge CLK) begin
      if (mem_clr) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
         sram_do <= 32'h0;
      end else if (!bus.SRAM_CSN) begin
         if (bus.SRAM_WE) begin
            for (int l = 0; l < 4; l++)
               if (bus.SRAM_BE[l]) mem[bus.SRAM_ADDR][8*l +: 8] <= bus.SRAM_DI[8*l +: 8];
         end else begin
            sram_do <= mem[bus.SRAM_ADDR];
         end
      end
   end
   assign bus.SRAM_DO = sram_do;

   logic [49:0] sram_bus;
   assign sram_bus = {bus.SRAM_CSN, bus.SRAM_WE, bus.SRAM_ADDR, bus.SRAM_BE, bus.SRAM_DI};

   int          n_checks;
   int          n_errors;
   logic [49:0] e;
   logic [31:0] d;

   function automatic logic [49:0] s_rd(input logic [AW-1:0] a);
      return {1'b0, 1'b0, a, 4'hF, 32'h0};
   endfunction

   function automatic logic [49:0] s_wr(input logic [AW-1:0] a, input logic [3:0] be,
                                        input logic [31:0] dat);
      return {1'b0, 1'b1, a, be, dat};
   endfunction

   task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [2:0] sz, input logic [31:0] wdata);
      bus.HSEL   = sel;
      bus.HTRANS = trans;
      bus.HADDR  = addr;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
      bus.HWDATA = wdata;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] wdata);
      drive(1'b1, 2'b10, addr, 1'b0, 3'd2, wdata);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wdata);
      drive(1'b1, 2'b10, addr, 1'b1, sz, wdata);
   endtask

   task automatic idle(input logic [31:0] wdata);
      drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, wdata);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; mem_clr = 1'b1; bus.HREADY = 1'b1; idle(32'h0);
      step();
      mem_clr = 1'b0;
      @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL rst_sram: got %h expected %h", sram_bus, c_IDLE); end
      n_checks++; if (bus.HRDATA !== 32'h0) begin n_errors++; $display("FAIL rst_hrdata: got %h expected 0", bus.HRDATA); end
      n_checks++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin n_errors++; $display("FAIL rst_resp: got %b expected 10", {bus.HREADYOUT, bus.HRESP}); end
      step();
      RST = 1'b0;
   endtask

   task automatic test_word();
      wr(32'h10, 3'd2, 32'h0); @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL word_addr_phase: got %h expected %h", sram_bus, c_IDLE); end
      step();
      idle(32'hDEADBEEF); @(negedge CLK);
      e = s_wr(12'd4, 4'hF, 32'hDEADBEEF);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL word_write: got %h expected %h", sram_bus, e); end
      step();
      rd(32'h10, 32'h0); @(negedge CLK);
      e = s_rd(12'd4);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL word_read_strobe: got %h expected %h", sram_bus, e); end
      step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'hDEADBEEF) begin n_errors++; $display("FAIL word_hrdata: got %h expected deadbeef", bus.HRDATA); end
      n_checks++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin n_errors++; $display("FAIL word_resp: got %b expected 10", {bus.HREADYOUT, bus.HRESP}); end
      step();
   endtask

   task automatic test_bytes();
      wr(32'h20, 3'd0, 32'h0); step();
      wr(32'h21, 3'd0, 32'h0000_0011); @(negedge CLK);
      e = s_wr(12'd8, 4'b0001, 32'h0000_0011);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL byte0: got %h expected %h", sram_bus, e); end
      step();
      wr(32'h22, 3'd0, 32'h0000_2200); @(negedge CLK);
      e = s_wr(12'd8, 4'b0010, 32'h0000_2200);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL byte1: got %h expected %h", sram_bus, e); end
      step();
      wr(32'h23, 3'd0, 32'h0033_0000); @(negedge CLK);
      e = s_wr(12'd8, 4'b0100, 32'h0033_0000);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL byte2: got %h expected %h", sram_bus, e); end
      step();
      rd(32'h20, 32'h4400_0000); @(negedge CLK);
      e = s_rd(12'd8);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL byte_rd_priority: got %h expected %h", sram_bus, e); end
      step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'h4433_2211) begin n_errors++; $display("FAIL byte_hrdata: got %h expected 44332211", bus.HRDATA); end
      e = s_wr(12'd8, 4'b1000, 32'h4400_0000);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL byte3_drain: got %h expected %h", sram_bus, e); end
      step();
      @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL byte_post_idle: got %h expected %h", sram_bus, c_IDLE); end
      step();
   endtask

   task automatic test_forward();
      wr(32'h30, 3'd2, 32'h0); step();
      rd(32'h30, 32'hCAFE_F00D); @(negedge CLK);
      e = s_rd(12'd12);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL fwd_rd_strobe: got %h expected %h", sram_bus, e); end
      step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL fwd_hrdata: got %h expected cafef00d", bus.HRDATA); end
      e = s_wr(12'd12, 4'hF, 32'hCAFE_F00D);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL fwd_drain: got %h expected %h", sram_bus, e); end
      step();
      @(negedge CLK);
      d = mem[12];
      n_checks++; if (d !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL fwd_mem12: got %h expected cafef00d", d); end
      step();
   endtask

   task automatic test_half();
      wr(32'h40, 3'd2, 32'h0); step();
      idle(32'h1122_3344); step();
      wr(32'h42, 3'd1, 32'h0); step();
      rd(32'h40, 32'hABCD_0000); step();
      idle(32'h0); @(negedge CLK);
      e = s_wr(12'd16, 4'b1100, 32'hABCD_0000);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL half_drain: got %h expected %h", sram_bus, e); end
      n_checks++; if (bus.HRDATA !== 32'hABCD_3344) begin n_errors++; $display("FAIL half_fwd_hrdata: got %h expected abcd3344", bus.HRDATA); end
      step();
      rd(32'h40, 32'h0); step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'hABCD_3344) begin n_errors++; $display("FAIL half_sram_hrdata: got %h expected abcd3344", bus.HRDATA); end
      step();
   endtask

   task automatic test_back_to_back();
      wr(32'h50, 3'd2, 32'h0); step();
      rd(32'h54, 32'h1234_5678); @(negedge CLK);
      e = s_rd(12'd21);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL b2b_rd54: got %h expected %h", sram_bus, e); end
      step();
      rd(32'h50, 32'h0); @(negedge CLK);
      e = s_rd(12'd20);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL b2b_rd50_held: got %h expected %h", sram_bus, e); end
      n_checks++; if (bus.HRDATA !== 32'h0) begin n_errors++; $display("FAIL b2b_no_fwd_mismatch: got %h expected 0", bus.HRDATA); end
      step();
      rd(32'h58, 32'h0); @(negedge CLK);
      e = s_rd(12'd22);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL b2b_rd58_held: got %h expected %h", sram_bus, e); end
      n_checks++; if (bus.HRDATA !== 32'h1234_5678) begin n_errors++; $display("FAIL b2b_fwd: got %h expected 12345678", bus.HRDATA); end
      step();
      idle(32'h0); @(negedge CLK);
      e = s_wr(12'd20, 4'hF, 32'h1234_5678);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL b2b_drain: got %h expected %h", sram_bus, e); end
      n_checks++; if (bus.HRDATA !== 32'h0) begin n_errors++; $display("FAIL b2b_rd58_data: got %h expected 0", bus.HRDATA); end
      step();
      @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL b2b_single_drain: got %h expected %h", sram_bus, c_IDLE); end
      step();
      rd(32'h50, 32'h0); step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'h1234_5678) begin n_errors++; $display("FAIL b2b_readback: got %h expected 12345678", bus.HRDATA); end
      step();
   endtask

   task automatic test_gating();
      bus.HREADY = 1'b0; rd(32'h10, 32'h0); @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL hready_low: got %h expected %h", sram_bus, c_IDLE); end
      step();
      bus.HREADY = 1'b1; drive(1'b1, 2'b01, 32'h10, 1'b0, 3'd2, 32'h0); @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL busy_ignored: got %h expected %h", sram_bus, c_IDLE); end
      n_checks++; if (bus.HRDATA !== 32'h0) begin n_errors++; $display("FAIL hready_low_dp: got %h expected 0", bus.HRDATA); end
      step();
      rd(32'h0001_0010, 32'h0); @(negedge CLK);
      e = s_rd(12'd4);
      n_checks++; if (sram_bus !== e) begin n_errors++; $display("FAIL alias_addr: got %h expected %h", sram_bus, e); end
      step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'hDEADBEEF) begin n_errors++; $display("FAIL alias_hrdata: got %h expected deadbeef", bus.HRDATA); end
      step();
   endtask

   task automatic test_reset_wb();
      wr(32'h60, 3'd2, 32'h0); step();
      rd(32'h64, 32'hA5A5_A5A5); step();
      RST = 1'b1; idle(32'h0); @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL rstwb_csn: got %h expected %h", sram_bus, c_IDLE); end
      n_checks++; if (bus.HRDATA !== 32'h0) begin n_errors++; $display("FAIL rstwb_hrdata: got %h expected 0", bus.HRDATA); end
      step();
      RST = 1'b0; @(negedge CLK);
      n_checks++; if (sram_bus !== c_IDLE) begin n_errors++; $display("FAIL rstwb_discard: got %h expected %h", sram_bus, c_IDLE); end
      step();
      d = mem[24];
      n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL rstwb_mem24: got %h expected 0", d); end
      rd(32'h60, 32'h0); step();
      idle(32'h0); @(negedge CLK);
      n_checks++; if (bus.HRDATA !== 32'h0) begin n_errors++; $display("FAIL rstwb_readback: got %h expected 0", bus.HRDATA); end
      step();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_word();
      test_bytes();
      test_forward();
      test_half();
      test_back_to_back();
      test_gating();
      test_reset_wb();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
